// File: rtl/dcache_mem_bridge.sv
// Bridge between a write-through data cache and a single-outstanding memory port.
// Stores are posted into a small buffer; loads wait for older stores to the same word.
module dcache_mem_bridge #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       up_req_i,
   input  logic                       up_we_i,
   input  logic [31:0]                up_addr_i,
   input  logic [3:0]                 up_be_i,
   input  logic [31:0]                up_wdata_i,
   output logic                       up_gnt_o,
   output logic                       up_rvalid_o,
   output logic [31:0]                up_rdata_o,
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [31:0]                mem_addr_o,
   output logic [3:0]                 mem_be_o,
   output logic [31:0]                mem_wdata_o,
   input  logic                       mem_gnt_i,
   input  logic                       mem_rvalid_i,
   input  logic [31:0]                mem_rdata_i,
   output logic [$clog2(DEPTH+1)-1:0] sb_count_o,
   output logic                       sb_empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, WAIT_RESP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ld_pend_q, ld_pend_d;
   logic [31:0]     ld_addr_q, ld_addr_d;
   logic [3:0]      ld_be_q, ld_be_d;
   logic            op_ld_q, op_ld_d;
   logic            rvalid_q, rvalid_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [31:0]     fifo_addr_q  [DEPTH];
   logic [3:0]      fifo_be_q    [DEPTH];
   logic [31:0]     fifo_wdata_q [DEPTH];

   logic            push, pop, hazard;
   logic [PW-1:0]   off;

   // Entry i is valid when its distance from the head is below the count.
   always_comb begin
      hazard = 1'b0;
      off    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr_q;
         if ((CW'(off) < count_q) && (fifo_addr_q[i][31:2] == ld_addr_q[31:2]))
            hazard = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ld_pend_d   = ld_pend_q;
      ld_addr_d   = ld_addr_q;
      ld_be_d     = ld_be_q;
      op_ld_d     = op_ld_q;
      rvalid_d    = 1'b0;
      rdata_d     = '0;
      push        = 1'b0;
      pop         = 1'b0;
      up_gnt_o    = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;

      if (!rst && up_req_i && !ld_pend_q)
         up_gnt_o = up_we_i ? (count_q < CW'(DEPTH)) : 1'b1;

      if (up_gnt_o) begin
         if (up_we_i) begin
            push     = 1'b1;
            rvalid_d = 1'b1;
         end else begin
            ld_pend_d = 1'b1;
            ld_addr_d = up_addr_i;
            ld_be_d   = up_be_i;
         end
      end

      case (state_q)
         IDLE: begin
            if (ld_pend_q && !hazard)
               state_d = LD_REQ;
            else if (count_q != '0)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = fifo_addr_q[rd_ptr_q];
            mem_be_o    = fifo_be_q[rd_ptr_q];
            mem_wdata_o = fifo_wdata_q[rd_ptr_q];
            if (mem_gnt_i) begin
               state_d = WAIT_RESP;
               op_ld_d = 1'b0;
            end
         end
         LD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = ld_addr_q;
            mem_be_o   = ld_be_q;
            if (mem_gnt_i) begin
               state_d = WAIT_RESP;
               op_ld_d = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (mem_rvalid_i) begin
               state_d = IDLE;
               if (op_ld_q) begin
                  rvalid_d  = 1'b1;
                  rdata_d   = mem_rdata_i;
                  ld_pend_d = 1'b0;
               end else begin
                  pop = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ld_pend_q <= 1'b0;
         ld_addr_q <= '0;
         ld_be_q   <= '0;
         op_ld_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ld_pend_q <= ld_pend_d;
         ld_addr_q <= ld_addr_d;
         ld_be_q   <= ld_be_d;
         op_ld_q   <= op_ld_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   // Buffer storage needs no reset; validity is carried by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q]  <= up_addr_i;
         fifo_be_q[wr_ptr_q]    <= up_be_i;
         fifo_wdata_q[wr_ptr_q] <= up_wdata_i;
      end
   end

   assign up_rvalid_o = rvalid_q;
   assign up_rdata_o  = rdata_q;
   assign sb_count_o  = count_q;
   assign sb_empty_o  = (count_q == '0);

endmodule
